// File: rtl/prime_detector_driver.sv
// Host-side initiator for the prime detector: serialises a request MSB-first,
// strobes start, waits (bounded) for done/prime and returns a response.
//
// state | meaning
// IDLE  | ready for a request, req_rdy high
// SHIFT | driving nbits serial bits, det_shift high
// START | one-cycle det_start pulse, timeout counter cleared
// WAIT  | waiting for det_done or timeout expiry
// RESP  | response presented until resp_rdy
module prime_detector_driver #(
  parameter int nbits   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [nbits-1:0] req_num,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [nbits-1:0] resp_num,
  output logic             resp_prime,
  output logic             resp_timeout,
  output logic             det_data,
  output logic             det_shift,
  output logic             det_start,
  input  logic             det_done,
  input  logic             det_prime
);

  localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [nbits-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [TW-1:0]    to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    det_shift = 1'b0;
    det_data  = 1'b0;
    det_start = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) state_nxt = SHIFT;
      end
      SHIFT: begin
        det_shift = 1'b1;
        det_data  = shreg[nbits-1];
        if (bit_cnt == '0) state_nxt = START;
      end
      START: begin
        det_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (det_done || (to_cnt == TO_LAST)) state_nxt = RESP;
      end
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      resp_num     <= '0;
      resp_prime   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            shreg        <= req_num;
            resp_num     <= req_num;
            bit_cnt      <= CNT_LAST;
            resp_prime   <= 1'b0;
            resp_timeout <= 1'b0;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - CW'(1);
        end
        START: to_cnt <= '0;
        WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          // done takes priority over a coincident timeout
          if (det_done) begin
            resp_prime   <= det_prime;
            resp_timeout <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            resp_prime   <= 1'b0;
            resp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
